// File: rtl/slv_sched_pkg.sv
// -----------------------------------------------------------------------------
// slv_sched_pkg
// Shared types and constants for the slave burst scheduler.
//   sched_state_t : scheduler FSM states (IDLE, BURST, FLUSH)
//   src_t         : source select, 0 = slv0, 1 = slv1
//   MODE_OFF      : slave mode value that means "inactive"
//   src_onehot()  : source select to one-hot grant vector
// -----------------------------------------------------------------------------
package slv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    typedef logic src_t;

    localparam logic [1:0] MODE_OFF = 2'b00;

    function automatic logic [1:0] src_onehot(input src_t src);
        return src ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/slv_burst_scheduler_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
// Ports:
//   req[1:0]  in   request per source (bit 0 = slv0, bit 1 = slv1)
//   rr_last   in   source that owned the most recent burst
//   gnt_valid out  at least one source is requesting
//   gnt_src   out  winning source; only meaningful when gnt_valid is high
// -----------------------------------------------------------------------------
module rr_pick2
    import slv_sched_pkg::*;
(
    input  logic [1:0] req,
    input  src_t       rr_last,
    output logic       gnt_valid,
    output src_t       gnt_src
);

    // NOTE: every signal written in always_comb gets a value on every path
    // (defaults first) so no latch can be inferred.
    always_comb begin
        gnt_valid = |req;
        gnt_src   = 1'b0;
        if (&req) begin
            // Contention: the source that did not own the last burst wins.
            gnt_src = ~rr_last;
        end else begin
            // Single (or no) requester: bit 1 decides directly.
            gnt_src = req[1];
        end
    end

endmodule

// File: rtl/slv_burst_scheduler.sv
// -----------------------------------------------------------------------------
// slv_burst_scheduler
// Burst-granular round-robin scheduler sharing one input FIFO between two
// slave streams. A grant is locked for a whole burst (up to BURST_LEN beats or
// until the owner's last flag), so the FIFO receives contiguous per-source
// runs tagged with a source bit. Intake stalls on FIFO almost-full and on
// master-complete. Accepted beats are written one cycle later through a
// registered write stage.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   slvN_mode[1:0]                slave processing mode, 2'b00 = inactive
//   slvN_data_valid               slave beat valid
//   slvN_data[DW-1:0]             slave beat data
//   slvN_proc_val[PV_W-1:0]       slave per-beat process value
//   slvN_last                     final beat of the slave's transfer
//   slvN_ready                    beat accepted when high together with valid
//   fifo_afull                    FIFO has at most one free entry
//   mstr_cmplt                    downstream master finished, freeze intake
//   fifo_wr_en                    FIFO write strobe
//   fifo_wdata[DW-1:0]            write data
//   fifo_wmode[1:0]               mode latched at grant time
//   fifo_wproc_val[PV_W-1:0]      proc_val of the written beat
//   fifo_wsrc                     source of the written beat (0 = slv0)
//   grant[1:0]                    one-hot owner, 2'b00 when no burst owns it
//   busy                          high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module slv_burst_scheduler
    import slv_sched_pkg::*;
#(
    parameter  int DW        = 32,
    parameter  int PV_W      = 8,
    parameter  int BURST_LEN = 16,
    localparam int CNT_W     = $clog2(BURST_LEN)
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic [1:0]      slv0_mode,
    input  logic            slv0_data_valid,
    input  logic [DW-1:0]   slv0_data,
    input  logic [PV_W-1:0] slv0_proc_val,
    input  logic            slv0_last,
    output logic            slv0_ready,

    input  logic [1:0]      slv1_mode,
    input  logic            slv1_data_valid,
    input  logic [DW-1:0]   slv1_data,
    input  logic [PV_W-1:0] slv1_proc_val,
    input  logic            slv1_last,
    output logic            slv1_ready,

    input  logic            fifo_afull,
    input  logic            mstr_cmplt,

    output logic            fifo_wr_en,
    output logic [DW-1:0]   fifo_wdata,
    output logic [1:0]      fifo_wmode,
    output logic [PV_W-1:0] fifo_wproc_val,
    output logic            fifo_wsrc,

    output logic [1:0]      grant,
    output logic            busy
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    sched_state_t     state;
    src_t             owner;
    src_t             rr_last;
    logic [1:0]       lmode;
    logic [CNT_W-1:0] cnt;

    // -------------------------------------------------------------------------
    // Request / stall decode and round-robin pick
    // -------------------------------------------------------------------------
    logic       stall;
    logic [1:0] req;
    logic       gnt_valid;
    src_t       gnt_src;

    assign stall = fifo_afull | mstr_cmplt;
    assign req   = {slv1_data_valid && (slv1_mode != MODE_OFF),
                    slv0_data_valid && (slv0_mode != MODE_OFF)};

    rr_pick2 u_pick (
        .req       (req),
        .rr_last   (rr_last),
        .gnt_valid (gnt_valid),
        .gnt_src   (gnt_src)
    );

    // -------------------------------------------------------------------------
    // Owner-side view of the slave interface
    // -------------------------------------------------------------------------
    logic            own_valid;
    logic            own_last;
    logic [1:0]      own_mode;
    logic [DW-1:0]   own_data;
    logic [PV_W-1:0] own_pv;

    assign own_valid = owner ? slv1_data_valid : slv0_data_valid;
    assign own_last  = owner ? slv1_last       : slv0_last;
    assign own_mode  = owner ? slv1_mode       : slv0_mode;
    assign own_data  = owner ? slv1_data       : slv0_data;
    assign own_pv    = owner ? slv1_proc_val   : slv0_proc_val;

    // Ready is combinational on stall and mode so that an almost-full FIFO or
    // an owner going inactive blocks the beat in the very same cycle.
    logic own_ready;
    logic accept;
    logic at_term;
    logic burst_end;

    assign own_ready  = (state == BURST) && !stall && (own_mode != MODE_OFF);
    assign slv0_ready = own_ready && (owner == 1'b0);
    assign slv1_ready = own_ready && (owner == 1'b1);
    assign accept     = own_ready && own_valid;
    assign at_term    = (cnt == CNT_W'(BURST_LEN - 1));
    // Terminal count and last on the same beat collapse into one end, so the
    // counter never needs to wrap.
    assign burst_end  = accept && (at_term || own_last);

    // -------------------------------------------------------------------------
    // Scheduler FSM with registered grant/busy
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr_last <= 1'b1;        // slv0 wins the first contention
            lmode   <= MODE_OFF;
            cnt     <= '0;
            grant   <= 2'b00;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!stall && gnt_valid) begin
                        owner <= gnt_src;
                        lmode <= gnt_src ? slv1_mode : slv0_mode;
                        cnt   <= '0;
                        grant <= src_onehot(gnt_src);
                        busy  <= 1'b1;
                        state <= BURST;
                    end
                end

                BURST: begin
                    if (own_mode == MODE_OFF) begin
                        // Owner went inactive: abort and insert a release gap.
                        rr_last <= owner;
                        grant   <= 2'b00;
                        state   <= FLUSH;
                    end else if (burst_end) begin
                        rr_last <= owner;
                        cnt     <= '0;
                        grant   <= 2'b00;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (accept) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    // Stall or owner valid low: grant and counter simply hold.
                end

                FLUSH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    grant <= 2'b00;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registered write stage (latency 1). Data fields only load on an accept
    // and otherwise keep the last written beat.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en     <= 1'b0;
            fifo_wdata     <= '0;
            fifo_wmode     <= MODE_OFF;
            fifo_wproc_val <= '0;
            fifo_wsrc      <= 1'b0;
        end else begin
            fifo_wr_en <= accept;
            if (accept) begin
                fifo_wdata     <= own_data;
                fifo_wmode     <= lmode;
                fifo_wproc_val <= own_pv;
                fifo_wsrc      <= owner;
            end
        end
    end

endmodule

// File: tb/tb_slv_burst_scheduler.sv
// -----------------------------------------------------------------------------
// tb_slv_burst_scheduler
// Directed self-checking bench for slv_burst_scheduler. Each slave is fed from
// a beat queue; every accepted beat pushes its expected FIFO write into a
// scoreboard, which is popped and compared one cycle later. Burst ownership
// runs (source, length) are logged from the grant output and compared against
// the expected grant sequence of each scenario.
// -----------------------------------------------------------------------------
module tb_slv_burst_scheduler;

    localparam int DW        = 32;
    localparam int PV_W      = 8;
    localparam int BURST_LEN = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      slv0_mode, slv1_mode;
    logic            slv0_data_valid, slv1_data_valid;
    logic [DW-1:0]   slv0_data, slv1_data;
    logic [PV_W-1:0] slv0_proc_val, slv1_proc_val;
    logic            slv0_last, slv1_last;
    logic            slv0_ready, slv1_ready;
    logic            fifo_afull, mstr_cmplt;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wdata;
    logic [1:0]      fifo_wmode;
    logic [PV_W-1:0] fifo_wproc_val;
    logic            fifo_wsrc;
    logic [1:0]      grant;
    logic            busy;

    always #5 clk = ~clk;

    slv_burst_scheduler #(
        .DW        (DW),
        .PV_W      (PV_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .slv0_mode       (slv0_mode),
        .slv0_data_valid (slv0_data_valid),
        .slv0_data       (slv0_data),
        .slv0_proc_val   (slv0_proc_val),
        .slv0_last       (slv0_last),
        .slv0_ready      (slv0_ready),
        .slv1_mode       (slv1_mode),
        .slv1_data_valid (slv1_data_valid),
        .slv1_data       (slv1_data),
        .slv1_proc_val   (slv1_proc_val),
        .slv1_last       (slv1_last),
        .slv1_ready      (slv1_ready),
        .fifo_afull      (fifo_afull),
        .mstr_cmplt      (mstr_cmplt),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_wdata      (fifo_wdata),
        .fifo_wmode      (fifo_wmode),
        .fifo_wproc_val  (fifo_wproc_val),
        .fifo_wsrc       (fifo_wsrc),
        .grant           (grant),
        .busy            (busy)
    );

    typedef struct {
        logic [DW-1:0]   data;
        logic [PV_W-1:0] pv;
        logic            last;
        logic [1:0]      mode;   // mode the write must carry (latched at grant)
    } beat_t;

    typedef struct {
        logic [DW-1:0]   data;
        logic [PV_W-1:0] pv;
        logic [1:0]      mode;
        logic            src;
    } wr_t;

    beat_t       q0[$], q1[$];
    wr_t         exp_q[$];
    int          b_src[$], b_len[$], e_src[$], e_len[$], acc_cyc[$];
    bit          en0, en1, pend;
    int          n_assert, n_fail, cyc, acc0, acc1, base0;
    logic        s_rdy0, s_rdy1, s_busy;
    logic [1:0]  s_grant, prev_grant;
    logic [42:0] last_fields;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        slv0_data_valid = en0 && (q0.size() > 0);
        slv1_data_valid = en1 && (q1.size() > 0);
        if (q0.size() > 0) begin
            slv0_data = q0[0].data; slv0_proc_val = q0[0].pv; slv0_last = q0[0].last;
        end else begin
            slv0_data = '0; slv0_proc_val = '0; slv0_last = 1'b0;
        end
        if (q1.size() > 0) begin
            slv1_data = q1[0].data; slv1_proc_val = q1[0].pv; slv1_last = q1[0].last;
        end else begin
            slv1_data = '0; slv1_proc_val = '0; slv1_last = 1'b0;
        end
    endtask

    task automatic load(input bit src, input int n, input logic [DW-1:0] base,
                        input logic [1:0] mode, input int last_at);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + DW'(i);
            b.pv   = base[7:0] ^ 8'(i * 5 + 1);
            b.last = (i == last_at - 1);
            b.mode = mode;
            if (src) q1.push_back(b);
            else     q0.push_back(b);
        end
        drive();
    endtask

    // One clock: sample/check at the negedge, then update stimulus #1 after
    // the posedge according to what was accepted.
    task automatic tick();
        logic a0, a1;
        wr_t  e, w;
        @(negedge clk);
        cyc++;
        check("wr_en", fifo_wr_en, pend);
        if (pend) begin
            e = exp_q.pop_front();
            if (fifo_wr_en)
                check("wr_fields", {fifo_wdata, fifo_wproc_val, fifo_wmode, fifo_wsrc},
                      {e.data, e.pv, e.mode, e.src});
            last_fields = {e.data, e.pv, e.mode, e.src};
        end else begin
            check("wr_hold", {fifo_wdata, fifo_wproc_val, fifo_wmode, fifo_wsrc}, last_fields);
        end
        pend = 1'b0;
        check("grant_onehot0", $onehot0(grant), 1);
        check("ready_owner", {slv1_ready, slv0_ready} & ~grant, 2'b00);
        s_rdy0 = slv0_ready; s_rdy1 = slv1_ready; s_busy = busy; s_grant = grant;
        a0 = slv0_ready && slv0_data_valid;
        a1 = slv1_ready && slv1_data_valid;
        if (grant != 2'b00 && grant != prev_grant) begin
            b_src.push_back(int'(grant[1]));
            b_len.push_back(0);
        end
        prev_grant = grant;
        if (a0 || a1) begin
            check("accept_in_grant", b_len.size() != 0, 1);
            if (b_len.size() != 0) b_len[b_len.size() - 1]++;
            acc_cyc.push_back(cyc);
            pend = 1'b1;
            if (a0) begin
                w.data = q0[0].data; w.pv = q0[0].pv; w.mode = q0[0].mode; w.src = 1'b0;
                acc0++;
            end else begin
                w.data = q1[0].data; w.pv = q1[0].pv; w.mode = q1[0].mode; w.src = 1'b1;
                acc1++;
            end
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        if (a0) void'(q0.pop_front());
        else if (a1) void'(q1.pop_front());
        drive();
    endtask

    task automatic wait_acc(input bit src, input int target, input int limit, input string tag);
        int i = 0;
        while (((src ? acc1 : acc0) < target) && i < limit) begin
            tick();
            i++;
        end
        check(tag, (src ? acc1 : acc0) >= target, 1);
    endtask

    task automatic drain(input string tag);
        int  i = 0;
        bit  done;
        do begin
            tick();
            i++;
            done = !slv0_data_valid && !slv1_data_valid && !s_busy && !pend;
        end while (!done && i < 400);
        check(tag, done, 1);
    endtask

    task automatic exp_burst(input int src, input int len);
        e_src.push_back(src);
        e_len.push_back(len);
    endtask

    task automatic expect_bursts(input string tag);
        int n;
        check($sformatf("%s_count", tag), b_src.size(), e_src.size());
        n = (b_src.size() < e_src.size()) ? b_src.size() : e_src.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_src%0d", tag, i), b_src[i], e_src[i]);
            check($sformatf("%s_len%0d", tag, i), b_len[i], e_len[i]);
        end
        b_src.delete(); b_len.delete(); e_src.delete(); e_len.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {grant, busy, fifo_wr_en, fifo_wsrc, fifo_wmode, fifo_wproc_val,
                    slv0_ready, slv1_ready, fifo_wdata}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; acc0 = 0; acc1 = 0;
        en0 = 0; en1 = 0; pend = 0; prev_grant = 2'b00; last_fields = '0;
        slv0_mode = 2'b00; slv1_mode = 2'b00;
        fifo_afull = 1'b0; mstr_cmplt = 1'b0;
        drive();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", s_busy, 0);

        // Both slaves valid continuously: slv0, slv1, slv0, slv1 bursts of 16
        slv0_mode = 2'b01; slv1_mode = 2'b10;
        load(0, 32, 32'h0000_1000, 2'b01, 0);
        load(1, 32, 32'h0000_2000, 2'b10, 0);
        en0 = 1; en1 = 1; drive();
        drain("rr_drain");
        exp_burst(0, 16); exp_burst(1, 16); exp_burst(0, 16); exp_burst(1, 16);
        expect_bursts("rr");
        en0 = 0; en1 = 0;

        // slv1 burst ends on last at beat 5 while slv0 waits; slv0 goes next
        load(1, 5, 32'h0000_3000, 2'b10, 5);
        load(1, 3, 32'h0000_3005, 2'b10, 3);
        load(0, 3, 32'h0000_4000, 2'b01, 3);
        en1 = 1; drive();
        wait_acc(1, acc1 + 1, 20, "last_start");
        en0 = 1; drive();
        drain("last_drain");
        exp_burst(1, 5); exp_burst(0, 3); exp_burst(1, 3);
        expect_bursts("last");
        en0 = 0; en1 = 0;

        // slv0 mode drops to 00 after beat 7: abort, one FLUSH cycle, slv1 next
        base0 = acc0;
        load(0, 12, 32'h0000_5000, 2'b01, 0);
        load(1, 4, 32'h0000_6000, 2'b10, 4);
        en0 = 1; drive();
        wait_acc(0, base0 + 1, 20, "drop_start");
        en1 = 1; drive();
        wait_acc(0, base0 + 7, 20, "drop_seven");
        slv0_mode = 2'b00;
        tick();
        check("drop_no_accept", s_rdy0, 0);
        check("drop_count", acc0, base0 + 7);
        tick();
        check("flush_readies", {s_rdy1, s_rdy0}, 2'b00);
        check("flush_busy", s_busy, 1);
        tick();
        check("flush_one_cycle", s_busy, 0);
        q0.delete(); en0 = 0; drive();
        drain("drop_drain");
        exp_burst(0, 7); exp_burst(1, 4);
        expect_bursts("drop");
        en1 = 0; slv0_mode = 2'b01;

        // fifo_afull for 4 cycles after beat 3; mid-burst mode change ignored
        base0 = acc0;
        load(0, 16, 32'h0000_7000, 2'b01, 0);
        load(0, 1, 32'h0000_7010, 2'b01, 1);
        en0 = 1; drive();
        wait_acc(0, base0 + 3, 20, "stall_start");
        fifo_afull = 1'b1;
        repeat (4) begin
            tick();
            check("stall_ready", s_rdy0, 0);
            check("stall_grant", s_grant, 2'b01);
        end
        check("stall_hold", acc0, base0 + 3);
        fifo_afull = 1'b0;
        tick();
        check("stall_resume", s_rdy0, 1);
        wait_acc(0, base0 + 8, 20, "mode_chg_start");
        slv0_mode = 2'b11;
        wait_acc(0, base0 + 12, 20, "mode_chg_end");
        slv0_mode = 2'b01;
        drain("stall_drain");
        exp_burst(0, 16); exp_burst(0, 1);
        expect_bursts("stall");
        en0 = 0;

        // Stall in IDLE blocks the grant; then slv0 alone, 20 beats -> 16 + 4
        acc_cyc.delete();
        fifo_afull = 1'b1;
        load(0, 20, 32'h0000_8000, 2'b01, 20);
        en0 = 1; drive();
        repeat (2) begin
            tick();
            check("idle_afull_grant", s_grant, 2'b00);
            check("idle_afull_busy", s_busy, 0);
        end
        fifo_afull = 1'b0; mstr_cmplt = 1'b1;
        repeat (2) begin
            tick();
            check("idle_cmplt_grant", s_grant, 2'b00);
            check("idle_cmplt_busy", s_busy, 0);
        end
        mstr_cmplt = 1'b0;
        drain("single_drain");
        check("single_accepts", acc_cyc.size(), 20);
        if (acc_cyc.size() == 20) begin
            check("single_back_to_back", acc_cyc[15] - acc_cyc[0], 15);
            check("single_bubble", acc_cyc[16] - acc_cyc[15], 2);
        end
        exp_burst(0, 16); exp_burst(0, 4);
        expect_bursts("single");
        en0 = 0;

        // Reset mid-burst with a write in flight; slv0 wins first afterwards
        base0 = acc0;
        load(0, 10, 32'h0000_9000, 2'b01, 0);
        en0 = 1; drive();
        wait_acc(0, base0 + 3, 20, "rst_start");
        check("rst_inflight", fifo_wr_en, 1);
        rst_n = 1'b0;
        pend = 1'b0; exp_q.delete(); q0.delete(); en0 = 0; last_fields = '0;
        drive();
        #1;
        check_all_zero("rst_async_zero");
        tick();
        check_all_zero("rst_next_cycle_zero");
        b_src.delete(); b_len.delete();
        rst_n = 1'b1;
        load(0, 2, 32'h0000_A000, 2'b01, 2);
        load(1, 2, 32'h0000_B000, 2'b10, 2);
        en0 = 1; en1 = 1; drive();
        drain("rst_drain");
        exp_burst(0, 2); exp_burst(1, 2);
        expect_bursts("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/slv_burst_scheduler.md
Name: slv_burst_scheduler

Overview:
- Burst-granular round-robin scheduler that shares the single input FIFO between two slave streams (slv0, slv1) of the image-processing accelerator.
- Locks a grant for a whole burst, so FIFO contents arrive in contiguous per-source runs tagged with a source bit.
- Stalls on FIFO almost-full and on master-complete.
- Replaces beat-level toggling with a clean state machine and a registered write stage.

Parameters:
- DW, 32, data width of slave and FIFO data.
- PV_W, 8, width of the proc_val side field.
- BURST_LEN, 16, maximum beats per grant (at least 2).
- CNT_W, $clog2(BURST_LEN), width of the beat counter (derived, do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- slv0_mode  in  2  slave 0 processing mode; 2'b00 = inactive
- slv0_data_valid  in  1  slave 0 beat valid
- slv0_data  in  DW  slave 0 beat data
- slv0_proc_val  in  PV_W  slave 0 per-beat process value
- slv0_last  in  1  slave 0 final beat of its transfer
- slv0_ready  out  1  slave 0 beat accepted this cycle when high with valid
- slv1_mode, slv1_data_valid, slv1_data, slv1_proc_val, slv1_last, slv1_ready  same as slave 0
- fifo_afull  in  1  FIFO has at most 1 free entry
- mstr_cmplt  in  1  downstream master finished; freeze intake
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wdata  out  DW  write data
- fifo_wmode  out  2  mode of the written beat
- fifo_wproc_val  out  PV_W  proc_val of the written beat
- fifo_wsrc  out  1  source of the written beat (0 = slv0, 1 = slv1)
- grant  out  2  one-hot current owner; 2'b00 in IDLE
- busy  out  1  high whenever state is not IDLE

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Ports named clk and rst_n.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_last = 1, so slv0 wins the first arbitration.
- Request: reqN = slvN_data_valid AND (slvN_mode != 0).
- stall = fifo_afull OR mstr_cmplt.

States: IDLE, BURST, FLUSH.
- IDLE:
  - If not stall and any request: pick owner by round robin. Both requesting: the source not equal to rr_last wins. One requesting: that one wins.
  - Latch owner and latched mode (the owner's slvN_mode), clear beat counter, go to BURST.
  - No beat is accepted in the IDLE cycle.
- BURST:
  - slv_ready of the owner = NOT stall. Non-owner ready = 0.
  - Accept = ready AND valid. Each accept increments the counter.
  - Burst ends on the accepting cycle when counter == BURST_LEN-1, or when slv_last is high. On end: rr_last = owner, go to IDLE.
  - If the owner mode reads 2'b00 in BURST: no accept that cycle; rr_last = owner; go to FLUSH.
  - Owner mode changes to a different nonzero value mid-burst: ignored; the latched mode is used for the whole burst.
- FLUSH: one cycle with all readies 0, then IDLE. This is the release gap for an aborted burst.
- Write stage (registered, latency 1):
  - An accepted beat in cycle N produces fifo_wr_en = 1 in cycle N+1.
  - fifo_wdata, fifo_wproc_val come from the beat; fifo_wmode is the latched mode; fifo_wsrc is the owner.
  - Otherwise fifo_wr_en = 0 and the data fields hold their previous values.
  - fifo_afull (rather than full) guarantees room for the one in-flight beat.
- Stall in BURST: the grant is held, no accepts, and the counter is frozen. A burst resumes when stall clears.
- Stall in IDLE: no new grant is issued.
- Owner valid low in BURST: the grant is held, with no timeout.
- Simultaneous last and counter terminal: a single end; the counter does not wrap.
- Reset mid-burst: immediate return to reset values. The in-flight write is dropped (fifo_wr_en = 0).
- Minimum bubble between bursts: 1 cycle (the IDLE cycle).

Decomposition:
- Package slv_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, BURST, FLUSH} sched_state_t
  - typedef logic src_t
  - localparam MODE_OFF = 2'b00
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], rr_last. Outputs: gnt_valid, gnt_src.
  - Instantiated once.

Test Plan:
- Only slv0 valid, mode 2'b01, 20 beats D0..D19, BURST_LEN=16 -> two grants: 16 writes with fifo_wsrc=0, one IDLE bubble, then 4 writes. Each write is 1 cycle after its accept.
- Both slaves valid continuously, modes 01 and 10 -> grant sequence slv0, slv1, slv0, each 16 beats. fifo_wmode is 01 and 10 respectively; no interleaving within a burst.
- slv1 burst with slv1_last on beat 5 while slv0 is requesting -> slv1 burst ends after 5 writes; the next grant is slv0.
- fifo_afull asserted after beat 3 for 4 cycles -> ready 0 for exactly those cycles and the counter holds at 3. The burst resumes; 16 writes in total, none lost or duplicated.
- slv0_mode drops to 00 after beat 7 -> 7 writes, one FLUSH cycle with both readies 0, then slv1 is granted.
- rst_n pulsed low mid-burst with an accept in flight -> next cycle all outputs are 0 and fifo_wr_en is 0. After release, the first grant goes to slv0.
